// File: rtl/countdown_hms.sv
// -----------------------------------------------------------------------------
// countdown_hms
//
// Loadable hours:minutes:seconds countdown timer. It counts down once per
// `tick` strobe (the shared 1 Hz enable of the timekeeping datapath). The
// count decrements through a seconds -> minutes -> hours borrow chain. A small
// IDLE/RUN/PAUSE/DONE state machine gates the counting. Expiry is flagged with
// a single-cycle `done` pulse.
//
// Parameters
//   HMAX  maximum hours value; larger load values are clamped to it
//   MMAX  maximum minutes value; minutes wrap to it on a borrow
//   SMAX  maximum seconds value; seconds wrap to it on a borrow
//
// Ports
//   clk    in   clock, every state change on its rising edge
//   rst    in   asynchronous active-high reset
//   ld     in   load d_h/d_m/d_s (clamped) into the count, go to IDLE
//   d_h    in   hours load value   [4:0]
//   d_m    in   minutes load value [5:0]
//   d_s    in   seconds load value [5:0]
//   start  in   begin or resume counting (IDLE or PAUSE only)
//   stop   in   pause counting (RUN only)
//   tick   in   one-cycle count enable
//   q_h    out  current hours      [4:0]
//   q_m    out  current minutes    [5:0]
//   q_s    out  current seconds    [5:0]
//   busy   out  high while the timer is in RUN
//   done   out  one-cycle pulse on expiry, or on a start with a zero count
//
// Event priority in every state: ld > stop > start > tick.
// -----------------------------------------------------------------------------
module countdown_hms #(
  parameter int HMAX = 23,
  parameter int MMAX = 59,
  parameter int SMAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [4:0] d_h,
  input  logic [5:0] d_m,
  input  logic [5:0] d_s,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  output logic [4:0] q_h,
  output logic [5:0] q_m,
  output logic [5:0] q_s,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] H_MAX = 5'(HMAX);
  localparam logic [5:0] M_MAX = 6'(MMAX);
  localparam logic [5:0] S_MAX = 6'(SMAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] h_q, h_d;
  logic [5:0] m_q, m_d;
  logic [5:0] s_q, s_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       cnt_zero;
  logic       cnt_one;
  logic       can_start;

  // Saturate an hours load value at its maximum.
  function automatic logic [4:0] clamp_h(input logic [4:0] v);
    return (v > H_MAX) ? H_MAX : v;
  endfunction

  // Saturate a minutes/seconds load value at the given maximum.
  function automatic logic [5:0] clamp_ms(input logic [5:0] v,
                                          input logic [5:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

  assign cnt_zero  = (h_q == 5'd0) && (m_q == 6'd0) && (s_q == 6'd0);
  // The last live count: the next tick is the expiring one.
  assign cnt_one   = (h_q == 5'd0) && (m_q == 6'd0) && (s_q == 6'd1);
  assign can_start = (state_q == S_IDLE) || (state_q == S_PAUSE);

  // Next-state, next-count and next-output logic.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    done_d  = 1'b0;

    if (ld) begin
      // A load aborts whatever was happening, so no done pulse here.
      h_d     = clamp_h(d_h);
      m_d     = clamp_ms(d_m, M_MAX);
      s_d     = clamp_ms(d_s, S_MAX);
      state_d = S_IDLE;
    end else if (stop && (state_q == S_RUN)) begin
      // Stop swallows a coincident tick: the count is frozen as-is.
      state_d = S_PAUSE;
    end else if (start && can_start) begin
      if (cnt_zero) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else if (tick && (state_q == S_RUN)) begin
      if (s_q != 6'd0) begin
        s_d = s_q - 6'd1;
      end else begin
        s_d = S_MAX;
        if (m_q != 6'd0) begin
          m_d = m_q - 6'd1;
        end else begin
          // RUN never holds 0:0:0, so hours is nonzero here.
          m_d = M_MAX;
          h_d = h_q - 5'd1;
        end
      end
      if (cnt_one) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d == S_RUN);
  end

  // State and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= 5'd0;
      m_q     <= 6'd0;
      s_q     <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q_h  = h_q;
  assign q_m  = m_q;
  assign q_s  = s_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_countdown_hms.sv
// -----------------------------------------------------------------------------
// tb_countdown_hms
//
// Directed-vector bench for countdown_hms with the default 23:59:59 limits.
// Inputs are driven just after a rising edge, and outputs are sampled 1 ns
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_countdown_hms;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld;
  logic [4:0] d_h;
  logic [5:0] d_m;
  logic [5:0] d_s;
  logic       start;
  logic       stop;
  logic       tick;
  logic [4:0] q_h;
  logic [5:0] q_m;
  logic [5:0] q_s;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  countdown_hms dut (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .d_h   (d_h),
    .d_m   (d_m),
    .d_s   (d_s),
    .start (start),
    .stop  (stop),
    .tick  (tick),
    .q_h   (q_h),
    .q_m   (q_m),
    .q_s   (q_s),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare count, busy and done against hand-computed values.
  task automatic chk_all(input string tag, input int h, input int m,
                         input int s, input logic b, input logic d);
    chk({tag, ".q"},    {15'd0, q_h, q_m, q_s}, {15'd0, h[4:0], m[5:0], s[5:0]});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
  endtask

  // Drive one cycle of inputs, clock it in, and return 1 ns after the edge.
  task automatic cyc(input logic i_ld, input int h, input int m, input int s,
                     input logic i_start, input logic i_stop,
                     input logic i_tick);
    ld    = i_ld;
    d_h   = h[4:0];
    d_m   = m[5:0];
    d_s   = s[5:0];
    start = i_start;
    stop  = i_stop;
    tick  = i_tick;
    @(posedge clk);
    #1;
    ld    = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic load(input int h, input int m, input int s);
    cyc(1'b1, h, m, s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tk();
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; d_h = '0; d_m = '0; d_s = '0;
    start = 1'b0; stop = 1'b0; tick = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    // Borrow chain: 2:00:00 -> 1:59:59
    load(2, 0, 0);
    chk_all("bc_load", 2, 0, 0, 1'b0, 1'b0);
    go();
    chk_all("bc_start", 2, 0, 0, 1'b1, 1'b0);
    tk();
    chk_all("bc_tick", 1, 59, 59, 1'b1, 1'b0);

    // Reset mid-run clears without a clock edge
    load(1, 0, 0);
    go();
    tk(); tk(); tk();
    chk_all("rr_run", 0, 59, 57, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("rr_async", 0, 0, 0, 1'b0, 1'b0);
    idle();
    rst = 1'b0;
    tk();
    chk_all("rr_tick_ignored", 0, 0, 0, 1'b0, 1'b0);

    // Expiry
    load(0, 0, 2);
    go();
    chk_all("ex_start", 0, 0, 2, 1'b1, 1'b0);
    tk();
    chk_all("ex_t1", 0, 0, 1, 1'b1, 1'b0);
    tk();
    chk_all("ex_t2", 0, 0, 0, 1'b0, 1'b1);
    idle();
    chk_all("ex_after", 0, 0, 0, 1'b0, 1'b0);
    tk();
    chk_all("ex_tick_done", 0, 0, 0, 1'b0, 1'b0);
    go();
    chk_all("ex_start_done", 0, 0, 0, 1'b0, 1'b0);

    // Pause and simultaneous stop+tick
    load(0, 1, 0);
    go();
    chk_all("pa_run", 0, 1, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    chk_all("pa_stop_tick", 0, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tk();
      chk_all("pa_held", 0, 1, 0, 1'b0, 1'b0);
    end
    go();
    chk_all("pa_resume", 0, 1, 0, 1'b1, 1'b0);
    tk();
    chk_all("pa_tick", 0, 0, 59, 1'b1, 1'b0);

    // Load clamping and zero start
    load(31, 63, 60);
    chk_all("cl_load", 23, 59, 59, 1'b0, 1'b0);
    load(0, 0, 0);
    chk_all("zs_load", 0, 0, 0, 1'b0, 1'b0);
    go();
    chk_all("zs_start", 0, 0, 0, 1'b0, 1'b1);
    idle();
    chk_all("zs_after", 0, 0, 0, 1'b0, 1'b0);

    // Load during run aborts to IDLE
    load(0, 0, 9);
    go();
    tk();
    chk_all("lr_run", 0, 0, 8, 1'b1, 1'b0);
    load(0, 0, 5);
    chk_all("lr_load", 0, 0, 5, 1'b0, 1'b0);
    tk();
    chk_all("lr_idle_tick", 0, 0, 5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_hms.md
# countdown_hms

Loadable hours/minutes/seconds countdown timer: the down-counting counterpart of the team's up-counting time-of-day counters. It decrements a H:M:S value once per `tick` enable using a borrow chain (seconds → minutes → hours). A small start/stop state machine controls it, and it signals expiry with a one-cycle `done` pulse. It sits beside the clock counters in the timekeeping datapath and shares their 1 Hz enable.

## Interface
- `HMAX`, default 23: maximum hours value; load values above it are clamped.
- `MMAX`, default 59: maximum minutes value; also the wrap value on borrow.
- `SMAX`, default 59: maximum seconds value; also the wrap value on borrow.

- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `ld` in 1: load `d_h`/`d_m`/`d_s` into the count.
- `d_h` in 5: hours load value.
- `d_m` in 6: minutes load value.
- `d_s` in 6: seconds load value.
- `start` in 1: begin or resume counting.
- `stop` in 1: pause counting.
- `tick` in 1: one-cycle count enable (1 Hz strobe).
- `q_h` out 5: current hours.
- `q_m` out 6: current minutes.
- `q_s` out 6: current seconds.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle expiry pulse.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE.
- Reset values: `q_h`=0, `q_m`=0, `q_s`=0, `busy`=0, `done`=0.
- Priority in every state: `ld` > `stop` > `start` > `tick`.
- `ld` (any state) loads the count and goes to IDLE.
  - Each field is clamped independently: `d_h`>HMAX → HMAX; `d_m`>MMAX → MMAX; `d_s`>SMAX → SMAX.
  - `ld` aborts a run; no `done` pulse.
- `start` in IDLE or PAUSE:
  - Count nonzero → RUN.
  - Count 0:0:0 → DONE, with a `done` pulse.
- `start` in RUN or DONE: ignored.
- `stop` in RUN → PAUSE, count held. In other states, ignored.
- `tick` in RUN decrements the count:
  - `q_s`≠0: `q_s`−1.
  - `q_s`=0: `q_s`←SMAX and borrow into minutes.
  - Minutes borrow: `q_m`≠0: `q_m`−1; else `q_m`←MMAX and borrow into hours.
  - Hours borrow: `q_h`−1.
  - An hours underflow is unreachable, because RUN never holds 0:0:0.
- A tick at count 0:0:1 → count 0:0:0, state DONE, `done` pulse.
- DONE holds 0:0:0 until the next `ld`.
- `tick` outside RUN is ignored. `tick` together with `stop` is ignored (no decrement).
- All arithmetic is unsigned, in field width. No field ever exceeds its MAX.

## Timing
- All outputs are registered.
- Count update is visible in the cycle after the edge that samples `tick`: 1-cycle latency.
- `busy` rises in the cycle after the edge that samples `start` and falls in the cycle after `stop`, `ld` or expiry.
- `done` is high for exactly one cycle: the first cycle in which `q` reads 0:0:0 after expiry, or the cycle after a `start` on a zero count. It is never high for two consecutive cycles.
- `rst` asserted mid-run clears count, state and outputs immediately (asynchronously). The first tick after release is ignored unless `start` has been given.
- Back-to-back ticks on consecutive cycles are legal; each decrements once.

## Test plan
- Reset mid-run:
  - Stimulus: load 1:00:00, start, 3 ticks, assert `rst`.
  - Required: q=0:0:0, `busy`=0, `done`=0 immediately, without waiting for a clock edge.
- Borrow chain:
  - Stimulus: load 2:00:00, start, 1 tick.
  - Required: q=1:59:59, `busy`=1, `done`=0.
- Expiry:
  - Stimulus: load 0:00:02, start, 2 ticks.
  - Required: q=0:0:1 then 0:0:0; `done`=1 for exactly one cycle, aligned with the first 0:0:0; state DONE; `busy`=0.
  - Follow-on: further ticks and `start` → q stays 0:0:0, no further `done`.
- Pause and simultaneous events:
  - Stimulus: run 0:01:00. Drive `stop`+`tick` in the same cycle, then 5 ticks, then `start`, then 1 tick.
  - Required: q=0:01:00 while paused, then 0:00:59.
- Load clamping and zero start:
  - Stimulus: `ld` with d=31:63:60.
  - Required: q=23:59:59.
  - Stimulus: `ld` 0:0:0, then `start`.
  - Required: `done` pulses once, `busy` stays 0.
- Load during run:
  - Stimulus: `ld` 0:0:5 while in RUN.
  - Required: q=0:0:5, state IDLE, `done`=0.
